// File: rtl/ila_playback_if.sv
// ila_playback_if: buffer write bus and played-back sample bus.
`timescale 1ns/1ps
interface ila_playback_if #(parameter int SIGNAL_W = 16, parameter int BUFFER_W = 5);
  logic                wr_en_i;
  logic [BUFFER_W-1:0] wr_addr_i;
  logic [SIGNAL_W-1:0] wr_data_i;
  logic [SIGNAL_W-1:0] signal_o;
  logic                valid_o;
  logic [BUFFER_W-1:0] index_o;
  modport master (output wr_en_i, wr_addr_i, wr_data_i, input signal_o, valid_o, index_o);
  modport slave (input wr_en_i, wr_addr_i, wr_data_i, output signal_o, valid_o, index_o);
endinterface

// File: rtl/ila_playback.sv
// ila_playback: plays a software-written sample buffer out with per-sample hold, optional trigger and circular mode.
`timescale 1ns/1ps
module ila_playback #(
  parameter int SIGNAL_W = 16,
  parameter int BUFFER_W = 5,
  parameter int HOLD_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [BUFFER_W-1:0] last_index_i,
  input  logic [HOLD_W-1:0]   hold_i,
  input  logic                circular_i,
  input  logic                trig_en_i,
  input  logic                trig_negate_i,
  input  logic                trigger_i,
  ila_playback_if.slave       bus,
  output logic                busy_o,
  output logic                armed_o,
  output logic                done_o
);
  typedef enum logic [1:0] {IDLE, ARMED, PLAY, DONE} state_t;
  state_t state, state_n;
  logic [SIGNAL_W-1:0] mem [2**BUFFER_W];
  logic [SIGNAL_W-1:0] rdata;
  logic [BUFFER_W-1:0] nidx, last_q;
  logic [HOLD_W-1:0]   cnt, hold_q;
  logic circ_q, trig_en_q, neg_q, first;
  logic start_ok, finish, run, take, go, ren;
  function automatic logic [BUFFER_W-1:0] nxt(input logic [BUFFER_W-1:0] i);
    return i == last_q ? '0 : i + 1'b1;
  endfunction
  always_comb begin
    start_ok = start_i && !stop_i && (state == IDLE || state == DONE);
    finish   = state == PLAY && !first && bus.valid_o && bus.index_o == last_q && cnt == hold_q && !circ_q;
    state_n  = stop_i ? IDLE
             : start_ok ? (trig_en_i ? ARMED : PLAY)
             : (state == ARMED && trig_en_q && (trigger_i ^ neg_q)) ? PLAY
             : finish ? DONE : state;
    run      = state == PLAY && state_n == PLAY;
    take     = run && !first && (!bus.valid_o || cnt == hold_q);
    go       = state_n == PLAY && state != PLAY;
    ren      = take || (run && first);
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : cke_i ? state_n : state;
  assign busy_o  = state == ARMED || state == PLAY;
  assign armed_o = state == ARMED;
  assign done_o  = state == DONE;
  // Read-first buffer; it is only read when the next entry is fetched, so late writes to unread entries show up.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (bus.wr_en_i) mem[bus.wr_addr_i] <= bus.wr_data_i;
      if (ren) rdata <= mem[nidx];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.signal_o <= '0;
      bus.valid_o  <= 1'b0;
      bus.index_o  <= '0;
      cnt          <= '0;
      first        <= 1'b0;
      nidx         <= '0;
      last_q       <= '0;
      hold_q       <= '0;
      circ_q       <= 1'b0;
      trig_en_q    <= 1'b0;
      neg_q        <= 1'b0;
    end else if (cke_i) begin
      if (start_ok) begin
        last_q    <= last_index_i;
        hold_q    <= hold_i;
        circ_q    <= circular_i;
        trig_en_q <= trig_en_i;
        neg_q     <= trig_negate_i;
      end
      if (go) begin
        first <= 1'b1;
        nidx  <= '0;
      end else if (first) begin
        first <= 1'b0;
        nidx  <= nxt(nidx);
      end else if (take) begin
        bus.signal_o <= rdata;
        bus.valid_o  <= 1'b1;
        bus.index_o  <= bus.valid_o ? nxt(bus.index_o) : '0;
        cnt          <= '0;
        nidx         <= nxt(nidx);
      end else if (run) cnt <= cnt + 1'b1;
      if (state_n != PLAY) bus.valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/ila_playback.md
ILA_PLAYBACK -- requirements
Module: ila_playback

Interface
REQ-001 SHALL have parameter SIGNAL_W, default 16: width of each played-back sample.
REQ-002 SHALL have parameter BUFFER_W, default 5: playback buffer address width, depth 2^BUFFER_W.
REQ-003 SHALL have parameter HOLD_W, default 8: width of per-sample hold count.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port cke_i, input, 1: clock enable; when 0, all state, including the buffer, holds.
REQ-007 SHALL have ports wr_en_i (1), wr_addr_i (BUFFER_W), wr_data_i (SIGNAL_W), all inputs: software buffer write port.
REQ-008 SHALL have ports start_i (1) and stop_i (1), inputs: single-cycle command pulses.
REQ-009 SHALL have ports last_index_i (BUFFER_W), hold_i (HOLD_W), circular_i (1), trig_en_i (1), trig_negate_i (1), all inputs: playback configuration.
REQ-010 SHALL have port trigger_i, input, 1: external start trigger.
REQ-011 SHALL have port signal_o, output, SIGNAL_W: registered played-back sample.
REQ-012 SHALL have port valid_o, output, 1: signal_o carries a buffer sample for the current playback.
REQ-013 SHALL have ports busy_o (1), armed_o (1), done_o (1), index_o (BUFFER_W), all outputs: status.

Function
REQ-014 SHALL implement FSM states IDLE, ARMED, PLAY and DONE; busy_o = ARMED|PLAY, armed_o = ARMED, done_o = DONE.
REQ-015 SHALL latch last_index_i, hold_i, circular_i, trig_en_i and trig_negate_i when start_i is accepted; later input changes do not affect the running playback.
REQ-016 In IDLE or DONE, start_i SHALL move the FSM to ARMED if trig_en_i=1, otherwise to PLAY; start_i in ARMED or PLAY SHALL be ignored.
REQ-017 In ARMED, the FSM SHALL enter PLAY on the first cycle where (trigger_i XOR latched trig_negate) = 1.
REQ-018 The buffer SHALL have one-cycle synchronous read latency and read-first behaviour: a write and a read to the same address in the same cycle returns the old data.
REQ-019 On entering PLAY, the index SHALL be 0; signal_o SHALL show buffer[0], with valid_o=1, exactly 2 cycles after the accepting start_i (or trigger) edge.
REQ-020 Each entry SHALL stay on signal_o for hold+1 cycles; hold=0 gives one sample per cycle.
REQ-021 After entry last_index has been held, the FSM SHALL wrap the index to 0 and continue if circular=1, otherwise go to DONE.
REQ-022 Index arithmetic SHALL be modulo 2^BUFFER_W; last_index = 2^BUFFER_W-1 plays the whole buffer.
REQ-023 In DONE, signal_o SHALL hold the last sample and valid_o SHALL be 0.
REQ-024 stop_i SHALL force IDLE on the next edge from any state; signal_o holds its value and valid_o goes to 0.
REQ-025 stop_i and start_i asserted in the same cycle: stop_i SHALL win.
REQ-026 index_o SHALL report the index of the entry currently on signal_o.
REQ-027 wr_en_i SHALL be accepted in every state; a write during PLAY is visible if that address has not yet been read in the current pass.

Reset
REQ-028 rst_i=1 on an edge SHALL set the FSM to IDLE and set signal_o=0, valid_o=0, busy_o=0, armed_o=0, done_o=0, index_o=0 and all latched configuration to 0.
REQ-029 Buffer contents SHALL NOT be cleared by reset.
REQ-030 Reset SHALL override cke_i, start_i and stop_i; rst_i asserted mid-PLAY SHALL abort playback, with IDLE outputs on the next cycle.

Verification
REQ-031 Write buffer[0..3]=A,B,C,D; last_index=3, hold=0, trig_en=0; pulse start -> signal_o = A,B,C,D on cycles +2..+5 with valid_o=1, then DONE with signal_o=D and valid_o=0.
REQ-032 Same setup with hold=2 -> each of A..D is held 3 cycles; done_o asserts 14 cycles after start.
REQ-033 circular=1, last_index=1 -> output repeats A,B,A,B...; stop_i -> IDLE on the next cycle, busy_o=0.
REQ-034 trig_en=1, trig_negate=1, trigger_i=1 for 10 cycles then 0 -> armed_o=1 throughout; A appears 2 cycles after trigger_i falls.
REQ-035 Reset pulsed mid-PLAY -> all outputs 0 on the next cycle; start again -> buffer contents replay unchanged.
REQ-036 cke_i=0 for 5 cycles mid-PLAY -> signal_o and index_o frozen; the sequence resumes without loss; start and stop in the same cycle -> FSM stays IDLE.
